// File: rtl/count_to_bcd_pkg.sv
// Shared definitions for the count_to_bcd converter.
// Holds the controller state encoding and the default widths. COUNT_W must
// track the count width of counter_16, which feeds this block directly.
package count_to_bcd_pkg;

    localparam int COUNT_W    = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/count_to_bcd_add3.sv
// Single-digit correction cell for shift-add-3 (double dabble) conversion.
// Ports:
//   din  : 4-bit BCD digit before the shift
//   dout : din + 3 when din >= 5, otherwise din unchanged
// Adding 3 before the left shift makes a digit of 5..9 carry correctly into
// the next decade once it is doubled. Inputs are always 0..9, so the sum
// never exceeds 12 and fits in 4 bits.
module count_to_bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/count_to_bcd.sv
// Sequential binary-to-BCD converter sitting downstream of counter_16.
// A start strobe snapshots bin; the snapshot is converted one bit per clock
// by shift-add-3, and the packed BCD result is published with a done pulse.
// The counter keeps running during a conversion; only the snapshot matters.
// Ports:
//   clock : rising-edge clock, shared with counter_16
//   reset : asynchronous, active-low reset
//   start : conversion request, only looked at while idle
//   bin   : binary value to convert (normally counter_16 count)
//   busy  : high while a conversion is running
//   done  : one-cycle pulse, bcd has just been updated
//   bcd   : packed BCD result, units in bcd[3:0]; held between conversions
module count_to_bcd
    import count_to_bcd_pkg::*;
#(
    parameter int BIT_SZ = COUNT_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIT_SZ-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIT_SZ);
    localparam int SCR_W = 4*DIGITS + BIT_SZ;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   corrected;
    logic [SCR_W-1:0]   shifted;
    logic               last_shift;

    // The BCD field occupies the top of the scratch register; every digit
    // gets its own add-3 cell, while the binary part passes straight through.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        count_to_bcd_add3 u_add3 (
            .din  (scratch[BIT_SZ + 4*g +: 4]),
            .dout (corrected[BIT_SZ + 4*g +: 4])
        );
    end

    assign corrected[BIT_SZ-1:0] = scratch[BIT_SZ-1:0];
    assign shifted               = {corrected[SCR_W-2:0], 1'b0};
    assign last_shift            = (state_q == ST_SHIFT) &&
                                   (bit_cnt == CNT_W'(BIT_SZ - 1));
    assign busy                  = (state_q == ST_SHIFT);

    // State register. Reset drops any conversion in flight straight back
    // to idle without producing a done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: idle waits for start, shift runs until the last bit
    // has been shifted in. A start seen while shifting is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)      state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Datapath: load the snapshot on an accepted start, then correct and
    // shift once per clock. The visible result is only written on the final
    // shift, so the outputs never show a half-converted value. done defaults
    // low every cycle so it stays a single-cycle pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scratch <= '0;
            bit_cnt <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        scratch <= {{(4*DIGITS){1'b0}}, bin};
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    scratch <= shifted;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_shift) begin
                        bcd  <= shifted[SCR_W-1:BIT_SZ];
                        done <= 1'b1;
                    end
                end
                default: begin
                    scratch <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_to_bcd.sv
// Self-checking bench for count_to_bcd.
// Expected BCD values come from a divide/modulo model and are queued when a
// conversion is launched; a negedge monitor pops them on each done pulse.
// The monitor also checks that bcd holds steady whenever no done is shown.
module tb_count_to_bcd;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_drv = '0;
    logic        live_mode = 1'b0;
    logic [15:0] live_cnt;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    logic [19:0] sb[$];
    logic [19:0] held_expect = '0;
    int          assertions = 0;
    int          failures = 0;
    int          done_count = 0;
    int          launched = 0;
    int          cyc;

    always #5 clock = ~clock;

    assign bin = live_mode ? live_cnt : bin_drv;

    // Stand-in for counter_16: free-running count used as a live bin source.
    always @(posedge clock or negedge reset) begin
        if (!reset) live_cnt <= '0;
        else        live_cnt <= live_cnt + 16'd1;
    end

    count_to_bcd dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    function automatic logic [19:0] bcdModel(input int value);
        logic [19:0] r;
        int          v;
        v = value;
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Called on a negedge: present value, raise start for one edge, queue result.
    task automatic applyStimulus(input logic [15:0] value);
        bin_drv = value;
        start   = 1'b1;
        sb.push_back(bcdModel(int'(value)));
        launched++;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!done && cycles < budget);
        if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (!reset) begin
            held_expect = '0;
        end else if (done) begin
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                held_expect = sb.pop_front();
                checkOutput("bcd_result", 32'(bcd), 32'(held_expect));
            end
        end else begin
            checkOutput("bcd_hold", 32'(bcd), 32'(held_expect));
        end
    end

    initial begin
        // Reset held for three cycles.
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_bcd", 32'(bcd), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Zero input: latency, busy profile, single-cycle done.
        applyStimulus(16'd0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        waitDone(40, cyc);
        checkOutput("latency_zero", 32'(cyc), 32'd16);
        checkOutput("busy_in_done_cycle", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);

        // Maximum and a typical value.
        applyStimulus(16'hFFFF);
        waitDone(40, cyc);
        @(negedge clock);
        applyStimulus(16'd12345);
        bin_drv = 16'd777;
        waitDone(40, cyc);
        checkOutput("latency_12345", 32'(cyc), 32'd16);
        @(negedge clock);

        // Live counter on bin: result is the count at the start edge.
        live_mode = 1'b1;
        repeat (5) @(negedge clock);
        start = 1'b1;
        sb.push_back(bcdModel(int'(live_cnt)));
        launched++;
        @(negedge clock);
        start = 1'b0;
        waitDone(40, cyc);
        live_mode = 1'b0;
        @(negedge clock);

        // Start held high: second request is taken in the done cycle only.
        bin_drv = 16'd9;
        start   = 1'b1;
        sb.push_back(bcdModel(9));
        launched++;
        @(negedge clock);
        bin_drv = 16'd10;
        sb.push_back(bcdModel(10));
        launched++;
        waitDone(40, cyc);
        checkOutput("held_first_latency", 32'(cyc), 32'd16);
        waitDone(40, cyc);
        checkOutput("held_done_spacing", 32'(cyc), 32'd17);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("held_stopped", 32'(busy), 32'd0);

        // Reset in the middle of a conversion.
        applyStimulus(16'd40000);
        sb.pop_back();
        launched--;
        repeat (7) @(negedge clock);
        checkOutput("busy_mid_conv", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_bcd", 32'(bcd), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("no_done_after_abort", 32'(done_count), 32'(launched));
        applyStimulus(16'd99);
        waitDone(40, cyc);
        @(negedge clock);

        // Back-to-back sweep: next start is raised in each done cycle.
        for (int v = 0; v < 1024; v++) begin
            applyStimulus(16'(v));
            waitDone(40, cyc);
        end
        for (int v = 9990; v <= 10010; v++) begin
            applyStimulus(16'(v));
            waitDone(40, cyc);
        end
        for (int v = 65500; v <= 65535; v++) begin
            applyStimulus(16'(v));
            waitDone(40, cyc);
        end
        for (int i = 0; i < 400; i++) begin
            applyStimulus(16'($urandom_range(65535, 0)));
            waitDone(40, cyc);
            checkOutput("sweep_latency", 32'(cyc), 32'd16);
        end
        @(negedge clock);
        @(negedge clock);

        checkOutput("queue_drained", 32'(sb.size()), 32'd0);
        checkOutput("done_count", 32'(done_count), 32'(launched));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
